hazard_stall_unit: RTL and testbench

ID-stage interlock for the 5-stage MIPS pipeline. Covers the hazards that the EX-stage forwarding unit cannot resolve. Detects load-use dependencies and holds PC and IF/ID while injecting bubbles into ID/EX for LOAD_STALL cycles. Also flushes the front end on a taken branch and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_unit.sv | 178 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// ID-stage interlock for the 5-stage MIPS pipeline. It covers the hazards the
// EX-stage forwarding unit cannot resolve:
//   * load-use: the EX instruction is a load whose destination is read by the
//     ID instruction. PC and IF/ID are held and ID/EX gets a bubble for
//     LOAD_STALL cycles.
//   * taken branch/jump resolved in EX: IF/ID is flushed, ID/EX gets a bubble
//     and any stall in progress is cancelled.
// A saturating counter records how many cycles the PC was held.
//
// The first stall cycle is raised combinationally in the same cycle the
// hazard is seen (IDLE). Any further cycles come from the STALL state, which
// keeps stalling whatever the ID/EX contents are doing.
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int unsigned REG_W      = 6,  // register-specifier width
  parameter int unsigned LOAD_STALL = 1,  // bubbles per load-use hazard, 1..7
  parameter int unsigned CNT_W      = 16  // stall performance counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  // ID stage
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  // EX stage
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  // Pipeline control
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  // Debug / status
  output logic [CNT_W-1:0] stall_cnt,
  output logic             busy
);

  // -------------------------------------------------------------------------
  // Local types and constants
  // -------------------------------------------------------------------------
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Cycles still owed after the first (combinational) stall cycle.
  localparam logic [2:0] REM_INIT  = 3'(LOAD_STALL - 1);
  // With a single-cycle penalty the FSM never needs to leave IDLE.
  localparam bit         MULTI_CYC = (LOAD_STALL > 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [2:0]       rem_q,   rem_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Raw (reset-independent) control decisions for the current cycle.
  logic hz;
  logic stall_raw;
  logic bubble_raw;
  logic flush_raw;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  // A load writing r0 never creates a dependency, and rt only matters when
  // the ID instruction actually reads it. Invalid stages never hazard, so
  // the term is fully defined even while the ID/EX payload is garbage.
  assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
              ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  // Branch redirect has priority over everything; otherwise stall on a fresh
  // hazard in IDLE or unconditionally while the STALL window is open.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    rem_d      = rem_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    flush_raw  = 1'b0;

    if (branch_taken) begin
      // The wrong-path instruction in IF/ID is discarded and the one entering
      // EX becomes a NOP; holding the PC would lose the branch target.
      flush_raw  = 1'b1;
      bubble_raw = 1'b1;
      state_d    = IDLE;
      rem_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (MULTI_CYC) begin
              state_d = STALL;
              rem_d   = REM_INIT;
            end
          end
        end

        STALL: begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          // rem counts the STALL-state cycles still to run, this one
          // included; the <= guard keeps a corrupted zero from locking up.
          if (rem_q <= 3'd1) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end

        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall performance counter (saturating)
  // -------------------------------------------------------------------------
  // Count every cycle the PC is held, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_raw && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // State, remaining-count and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The IDLE-state stall is purely combinational, so the controls are
  // qualified with rst_n to force them low for the whole reset interval,
  // including the moment reset asserts between clock edges. The counter
  // path uses the unqualified decision; it is held in reset anyway.
  assign pc_stall     = stall_raw  & rst_n;
  assign if_id_stall  = stall_raw  & rst_n;
  assign id_ex_bubble = bubble_raw & rst_n;
  assign if_id_flush  = flush_raw  & rst_n;

  assign stall_cnt    = cnt_q;
  assign busy         = (state_q == STALL);

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Four instances share one stimulus stream:
//   d0: LOAD_STALL=1, CNT_W=16   d1: LOAD_STALL=3, CNT_W=16
//   d2: LOAD_STALL=5, CNT_W=16   d3: LOAD_STALL=2, CNT_W=3 (saturates at 7)
// The reference model describes a stall as a window of cycle numbers
// [start, start+LOAD_STALL-1] that a taken branch truncates; every cycle all
// instances are compared with it. A vector table and hand-written sequences
// add fixed expected values for the single-cycle and multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int REG_W = 6;
  localparam int NDUT  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;

  logic [NDUT-1:0]  ps;
  logic [NDUT-1:0]  ifs;
  logic [NDUT-1:0]  bub;
  logic [NDUT-1:0]  fl;
  logic [NDUT-1:0]  bsy;
  logic [15:0]      cnt_w [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LS = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 2;
    localparam int unsigned CW = (g == 3) ? 3 : 16;
    logic [CW-1:0] c;

    hazard_stall_unit #(
      .REG_W     (REG_W),
      .LOAD_STALL(LS),
      .CNT_W     (CW)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .branch_taken(branch_taken),
      .pc_stall    (ps[g]),
      .if_id_stall (ifs[g]),
      .id_ex_bubble(bub[g]),
      .if_id_flush (fl[g]),
      .stall_cnt   (c),
      .busy        (bsy[g])
    );

    assign cnt_w[g] = 16'(c);
  end

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: stall windows in absolute cycle numbers
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic stall;
    logic bubble;
    logic flush;
    logic busy;
  } exp_t;

  int          ls_m [NDUT] = '{1, 3, 5, 2};
  int unsigned cmax [NDUT] = '{65535, 65535, 65535, 7};
  int          start_c [NDUT];
  int          end_c   [NDUT];
  int unsigned cnt_m   [NDUT];
  int          cyc;

  function automatic bit model_hz();
    return id_valid && ex_valid && ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // Cycles strictly after the hazard cycle and up to the window end are the
  // ones spent in the STALL state.
  function automatic bit in_window(int d);
    return (cyc > start_c[d]) && (cyc <= end_c[d]);
  endfunction

  function automatic exp_t model_out(int d);
    exp_t e;
    e = '0;
    if (!rst_n) return e;
    e.busy = in_window(d);
    if (branch_taken) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
    end else if (in_window(d) || model_hz()) begin
      e.stall  = 1'b1;
      e.bubble = 1'b1;
    end
    return e;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < NDUT; d++) begin
      exp_t e;
      e = model_out(d);
      if (!rst_n) begin
        cnt_m[d]   = 0;
        start_c[d] = cyc;
        end_c[d]   = cyc;
      end else begin
        if (branch_taken) begin
          end_c[d] = cyc;
        end else if (!in_window(d) && model_hz()) begin
          start_c[d] = cyc;
          end_c[d]   = cyc + ls_m[d] - 1;
        end
        if (e.stall && (cnt_m[d] < cmax[d])) cnt_m[d]++;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int d = 0; d < NDUT; d++) begin
      exp_t        e;
      int unsigned ec;
      e  = model_out(d);
      ec = rst_n ? cnt_m[d] : 0;
      check($sformatf("d%0d.pc_stall@c%0d", d, cyc),     32'(ps[d]),  32'(e.stall));
      check($sformatf("d%0d.if_id_stall@c%0d", d, cyc),  32'(ifs[d]), 32'(e.stall));
      check($sformatf("d%0d.id_ex_bubble@c%0d", d, cyc), 32'(bub[d]), 32'(e.bubble));
      check($sformatf("d%0d.if_id_flush@c%0d", d, cyc),  32'(fl[d]),  32'(e.flush));
      check($sformatf("d%0d.busy@c%0d", d, cyc),         32'(bsy[d]), 32'(e.busy));
      check($sformatf("d%0d.stall_cnt@c%0d", d, cyc),    32'(cnt_w[d]), ec);
    end
  endtask

  // Compare on the falling edge, advance the model, then return just after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set_in(input logic iv, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic urt, input logic ev, input logic mr,
                        input logic [REG_W-1:0] rd, input logic br);
    id_valid     = iv;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_valid     = ev;
    ex_mem_read  = mr;
    ex_rd        = rd;
    branch_taken = br;
  endtask

  task automatic clear_in();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Load r5 in EX, ID reads r5 through rs.
  task automatic set_hz();
    set_in(1'b1, 6'd5, 6'd0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0);
  endtask

  task automatic reset_all();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Single-cycle vector table (checked on d0, which never leaves IDLE)
  // -------------------------------------------------------------------------
  typedef struct {
    logic             iv;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             urt;
    logic             ev;
    logic             mr;
    logic [REG_W-1:0] rd;
    logic             br;
    logic             e_stall;
    logic             e_flush;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                              input logic urt, input logic ev, input logic mr,
                              input logic [REG_W-1:0] rd, input logic br,
                              input logic e_stall, input logic e_flush);
    vec_t v;
    v.iv = iv; v.rs = rs; v.rt = rt; v.urt = urt; v.ev = ev; v.mr = mr;
    v.rd = rd; v.br = br; v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  vec_t vecs [12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    //             iv rs     rt     urt ev mr rd     br  stall flush
    vecs[0]  = mk(1, 6'd5,  6'd0,  0,  1, 1, 6'd5,  0,  1, 0); // load-use on rs
    vecs[1]  = mk(1, 6'd1,  6'd5,  0,  1, 1, 6'd5,  0,  0, 0); // rt match, rt unused
    vecs[2]  = mk(1, 6'd1,  6'd5,  1,  1, 1, 6'd5,  0,  1, 0); // rt match, rt used
    vecs[3]  = mk(1, 6'd0,  6'd0,  1,  1, 1, 6'd0,  0,  0, 0); // r0 never hazards
    vecs[4]  = mk(1, 6'd5,  6'd0,  0,  1, 0, 6'd5,  0,  0, 0); // EX not a load
    vecs[5]  = mk(1, 6'd5,  6'd0,  0,  0, 1, 6'd5,  0,  0, 0); // EX invalid
    vecs[6]  = mk(0, 6'd5,  6'd0,  0,  1, 1, 6'd5,  0,  0, 0); // ID invalid
    vecs[7]  = mk(1, 6'd5,  6'd0,  0,  1, 1, 6'd5,  1,  0, 1); // hazard + branch
    vecs[8]  = mk(1, 6'd3,  6'd4,  1,  1, 1, 6'd7,  0,  0, 0); // no register match
    vecs[9]  = mk(1, 6'd63, 6'd0,  0,  1, 1, 6'd63, 0,  1, 0); // top register
    vecs[10] = mk(0, 6'd0,  6'd0,  0,  0, 0, 6'd0,  1,  0, 1); // branch alone
    vecs[11] = mk(1, 6'd0,  6'd63, 1,  1, 1, 6'd63, 0,  1, 0); // rt-only, top reg

    cyc = 1;
    for (int d = 0; d < NDUT; d++) begin
      start_c[d] = 0;
      end_c[d]   = 0;
      cnt_m[d]   = 0;
    end

    // Reset state
    clear_in();
    rst_n = 1'b0;
    #2;
    check("reset.pc_stall",  32'(ps),  32'd0);
    check("reset.flush",     32'(fl),  32'd0);
    check("reset.busy",      32'(bsy), 32'd0);
    check("reset.stall_cnt", 32'(cnt_w[1]), 32'd0);
    // A hazard presented while in reset must not raise any control.
    set_hz();
    #1;
    check("reset_hz.pc_stall", 32'(ps),  32'd0);
    check("reset_hz.bubble",   32'(bub), 32'd0);
    clear_in();
    reset_all();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].ev,
             vecs[i].mr, vecs[i].rd, vecs[i].br);
      #1;
      check($sformatf("vec%0d.pc_stall", i),     32'(ps[0]),  32'(vecs[i].e_stall));
      check($sformatf("vec%0d.if_id_stall", i),  32'(ifs[0]), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d.id_ex_bubble", i), 32'(bub[0]),
            32'(vecs[i].e_stall | vecs[i].e_flush));
      check($sformatf("vec%0d.if_id_flush", i),  32'(fl[0]),  32'(vecs[i].e_flush));
      tick();
    end
    clear_in();

    // LOAD_STALL=1: one stall cycle, counter 0 -> 1, never busy
    reset_all();
    set_hz();
    #1;
    check("ls1.T.pc_stall", 32'(ps[0]),  32'd1);
    check("ls1.T.bubble",   32'(bub[0]), 32'd1);
    check("ls1.T.busy",     32'(bsy[0]), 32'd0);
    check("ls1.T.cnt",      32'(cnt_w[0]), 32'd0);
    tick();
    clear_in();
    #1;
    check("ls1.T1.pc_stall", 32'(ps[0]),  32'd0);
    check("ls1.T1.busy",     32'(bsy[0]), 32'd0);
    check("ls1.T1.cnt",      32'(cnt_w[0]), 32'd1);
    tick();

    // LOAD_STALL=3: stall T..T+2, busy T+1..T+2, quiet at T+3, count 3
    reset_all();
    set_hz();
    #1;
    check("ls3.T.pc_stall", 32'(ps[1]),  32'd1);
    check("ls3.T.busy",     32'(bsy[1]), 32'd0);
    tick();
    clear_in();
    for (int k = 1; k <= 2; k++) begin
      #1;
      check($sformatf("ls3.T%0d.pc_stall", k), 32'(ps[1]),  32'd1);
      check($sformatf("ls3.T%0d.bubble", k),   32'(bub[1]), 32'd1);
      check($sformatf("ls3.T%0d.busy", k),     32'(bsy[1]), 32'd1);
      tick();
    end
    #1;
    check("ls3.T3.pc_stall", 32'(ps[1]),  32'd0);
    check("ls3.T3.bubble",   32'(bub[1]), 32'd0);
    check("ls3.T3.busy",     32'(bsy[1]), 32'd0);
    check("ls3.T3.cnt",      32'(cnt_w[1]), 32'd3);
    tick();

    // Branch at T+1 cancels a LOAD_STALL=3 stall
    reset_all();
    set_hz();
    tick();
    clear_in();
    branch_taken = 1'b1;
    #1;
    check("bcan.T1.flush",       32'(fl[1]),  32'd1);
    check("bcan.T1.bubble",      32'(bub[1]), 32'd1);
    check("bcan.T1.pc_stall",    32'(ps[1]),  32'd0);
    check("bcan.T1.if_id_stall", 32'(ifs[1]), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("bcan.T2.pc_stall", 32'(ps[1]),  32'd0);
    check("bcan.T2.bubble",   32'(bub[1]), 32'd0);
    check("bcan.T2.flush",    32'(fl[1]),  32'd0);
    check("bcan.T2.busy",     32'(bsy[1]), 32'd0);
    check("bcan.T2.cnt",      32'(cnt_w[1]), 32'd1);
    tick();

    // Hazard and branch together in IDLE: branch only, no stall started
    reset_all();
    set_hz();
    branch_taken = 1'b1;
    #1;
    check("simul.flush",    32'(fl[1]),  32'd1);
    check("simul.bubble",   32'(bub[1]), 32'd1);
    check("simul.pc_stall", 32'(ps[1]),  32'd0);
    tick();
    clear_in();
    #1;
    check("simul.next.busy", 32'(bsy[1]), 32'd0);
    check("simul.next.cnt",  32'(cnt_w[1]), 32'd0);
    tick();

    // Asynchronous reset in the middle of a LOAD_STALL=5 stall
    reset_all();
    set_hz();
    tick();
    clear_in();
    tick();
    #1;
    check("arst.pre.pc_stall", 32'(ps[2]),  32'd1);
    check("arst.pre.busy",     32'(bsy[2]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.pc_stall", 32'(ps[2]),  32'd0);
    check("arst.bubble",   32'(bub[2]), 32'd0);
    check("arst.busy",     32'(bsy[2]), 32'd0);
    check("arst.cnt",      32'(cnt_w[2]), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("arst.after%0d.pc_stall", k), 32'(ps[2]),  32'd0);
      check($sformatf("arst.after%0d.busy", k),     32'(bsy[2]), 32'd0);
      tick();
    end
    set_hz();
    #1;
    check("arst.new_hz.pc_stall", 32'(ps[2]), 32'd1);
    tick();
    clear_in();
    tick();

    // Counter saturation on the 3-bit instance (holds at 7)
    reset_all();
    set_hz();
    for (int k = 0; k < 10; k++) tick();
    check("sat.cnt_a",    32'(cnt_w[3]), 32'd7);
    check("sat.pc_stall", 32'(ps[3]),    32'd1);
    for (int k = 0; k < 3; k++) tick();
    check("sat.cnt_b", 32'(cnt_w[3]), 32'd7);
    clear_in();
    tick();

    // Randomised traffic against the window model
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 299) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      id_uses_rt   = $urandom_range(0, 1) == 1;
      id_rs        = REG_W'($urandom_range(0, 3));
      id_rt        = REG_W'($urandom_range(0, 3));
      ex_rd        = REG_W'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_n = 1'b1;
    clear_in();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
